stream_sign_flip_hls_deadlock_reporter: RTL and testbench
=========================================================

// Module: stream_sign_flip_hls_deadlock_reporter
// PURPOSE
//   Downstream consumer of the per-instance deadlock monitors' `block` outputs.
//   Turns a raw "stream blocked this cycle" level into a qualified deadlock event:
//   the level must persist for THRESHOLD consecutive cycles.
//   Latches a sticky flag and first-fault info (monitor index, cycle stamp), and
//   counts events for the AXI-Lite status block / debug ILA.
// PARAMETERS
//   NUM_MON    4     number of monitor `block` inputs aggregated
//   THRESHOLD  1024  consecutive blocked cycles that qualify a deadlock (>=2)
//   TS_W       32    width of free-running cycle stamp
//   EVT_W      16    width of saturating event counter
// PORTS
//   clock           in   1                     single system clock
//   reset           in   1                     synchronous, active-high reset
//   block_in        in   NUM_MON               per-monitor block level (bit i = monitor i)
//   clear           in   1                     1-cycle pulse: clear sticky flag, capture, counter
//   deadlock        out  1                     sticky: qualified deadlock seen since last clear
//   deadlock_pulse  out  1                     1-cycle strobe per qualified event
//   deadlock_idx    out  $clog2(NUM_MON) (min 1)  index of first-fault monitor
//   deadlock_ts     out  TS_W                  cycle stamp of first fault
//   event_count     out  EVT_W                 saturating count of qualified events
// BEHAVIOUR
//   - Reset: all outputs 0, all stall timers 0, cycle stamp 0, FSM=IDLE.
//   - Cycle stamp: free-running TS_W counter, +1 every cycle, wraps at 2^TS_W-1 -> 0.
//   - Per-monitor stall timer i:
//     - block_in[i]=0: timer <= 0, armed <= 1.
//     - block_in[i]=1: timer <= min(timer+1, THRESHOLD).
//     - Event i fires in the cycle where block_in[i]=1, timer==THRESHOLD-1, armed=1.
//       That cycle then sets armed <= 0.
//     - Re-arming requires block_in[i] to drop for >=1 cycle.
//     - A persistent stall therefore yields exactly one event.
//   - Timing: block_in[i] high on sampled edges k .. k+THRESHOLD-1.
//     Registered outputs update at edge k+THRESHOLD-1, visible the following cycle.
//     Latency = THRESHOLD cycles from the first high sample.
//   - Simultaneous events: lowest index wins for deadlock_idx.
//     event_count increments by 1 per cycle, not per monitor.
//   - FSM IDLE/LATCHED:
//     - IDLE + any event -> LATCHED. Capture idx and the stamp of that cycle.
//       deadlock <= 1.
//     - LATCHED + event -> stay. idx/ts NOT overwritten (first-fault).
//       Pulse and count still update.
//     - clear -> IDLE. deadlock, idx, ts, event_count <= 0.
//       Stall timers and armed bits are untouched, so a still-stalled monitor does not re-fire.
//   - clear and event in the same cycle: clear applies first, then the event.
//     Result: deadlock=1, idx/ts = this event, event_count=1, pulse=1.
//   - deadlock_pulse is high in exactly the cycle after each event cycle, otherwise 0.
//   - event_count saturates at 2^EVT_W-1 and does not wrap.
//   - Reset mid-stall: timers cleared. A stall still present after reset needs a full
//     THRESHOLD cycles to qualify.
//   - All outputs are registered; no combinational path from inputs to outputs.
// STRUCTURE
//   - Package stream_sign_flip_hls_deadlock_pkg holds:
//     - IDLE/LATCHED state encoding;
//     - default THRESHOLD;
//     - the idx width function clog2_min1.
//   - Sub-module stream_sign_flip_hls_stall_timer: one per monitor, generate-loop.
//     I/O: clock, reset, block, fire; holds the timer and armed bit.
//   - Top holds:
//     - priority encoder;
//     - FSM;
//     - cycle stamp;
//     - capture registers;
//     - event counter.
// TESTING (NUM_MON=4, THRESHOLD=8, EVT_W=4)
//   - block_in[2] high 8 cycles from stamp 10 -> pulse once.
//     deadlock=1, idx=2, ts=17, event_count=1.
//   - block_in[1] high 7 cycles then low -> no pulse, deadlock stays 0.
//     Timer restarts on the next rise.
//   - block_in[3] and [1] rise together, 8 cycles -> one pulse, idx=1, event_count=1.
//     Later [0] qualifies: count=2, idx still 1.
//   - Stall persists 40 cycles with clear in cycle 20 -> one event only.
//     deadlock=0 after clear, no re-fire until block drops and re-qualifies.
//   - 20 separate qualified stalls -> event_count saturates at 15.
//     clear coincident with an event -> event_count=1, deadlock=1.
//   - reset asserted at timer=5 of an ongoing stall -> outputs 0.
//     Deadlock qualifies 8 cycles after reset deasserts.

Source files
------------

// File: rtl/stream_sign_flip_hls_deadlock_pkg.sv
// Shared types and helpers for the stream deadlock reporter.
// Holds the FSM state encoding, the default qualification threshold and the index-width helper.
package stream_sign_flip_hls_deadlock_pkg;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_LATCHED = 1'b1
  } dl_state_t;

  localparam int DEFAULT_THRESHOLD = 1024;

  // A single monitor still needs a 1-bit index port.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_sign_flip_hls_stall_timer.sv
// Per-monitor stall timer: fire is high in the cycle block has been high for THRESHOLD samples.
// Latency THRESHOLD-1 cycles to fire; one fire per stall, re-arms only after block drops.
module stream_sign_flip_hls_stall_timer
  import stream_sign_flip_hls_deadlock_pkg::*;
#(
  parameter int THRESHOLD = DEFAULT_THRESHOLD
) (
  input  logic clock,
  input  logic reset,
  input  logic block,
  output logic fire
);

  localparam int CNT_W = $clog2(THRESHOLD + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(THRESHOLD - 1);
  localparam logic [CNT_W-1:0] MAX  = CNT_W'(THRESHOLD);

  logic [CNT_W-1:0] timer;
  logic             armed;

  assign fire = block && armed && (timer == LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      timer <= '0;
      armed <= 1'b1;
    end else if (!block) begin
      timer <= '0;
      armed <= 1'b1;
    end else begin
      if (timer != MAX) timer <= timer + 1'b1;
      // Disarm so a stall that never drops reports only once.
      if (fire) armed <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_sign_flip_hls_deadlock_reporter.sv
// Qualifies per-monitor block levels into deadlock events with sticky first-fault capture and count.
// Outputs registered, THRESHOLD cycles from first high sample; no backpressure (pure observer).
module stream_sign_flip_hls_deadlock_reporter
  import stream_sign_flip_hls_deadlock_pkg::*;
#(
  parameter int NUM_MON   = 4,
  parameter int THRESHOLD = DEFAULT_THRESHOLD,
  parameter int TS_W      = 32,
  parameter int EVT_W     = 16
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_MON-1:0]              block_in,
  input  logic                            clear,
  output logic                            deadlock,
  output logic                            deadlock_pulse,
  output logic [clog2_min1(NUM_MON)-1:0]  deadlock_idx,
  output logic [TS_W-1:0]                 deadlock_ts,
  output logic [EVT_W-1:0]                event_count
);

  localparam int IDX_W = clog2_min1(NUM_MON);
  localparam logic [EVT_W-1:0] EVT_MAX = '1;

  logic [NUM_MON-1:0] fire;
  logic               any_fire;
  logic [IDX_W-1:0]   first_idx;
  logic [TS_W-1:0]    stamp;
  dl_state_t          state;

  for (genvar g = 0; g < NUM_MON; g++) begin : g_timer
    stream_sign_flip_hls_stall_timer #(
      .THRESHOLD (THRESHOLD)
    ) u_timer (
      .clock (clock),
      .reset (reset),
      .block (block_in[g]),
      .fire  (fire[g])
    );
  end

  assign any_fire = |fire;

  // Scan downward so the lowest firing index is the one left standing.
  always_comb begin
    first_idx = '0;
    for (int i = NUM_MON - 1; i >= 0; i--) begin
      if (fire[i]) first_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      stamp          <= '0;
      deadlock       <= 1'b0;
      deadlock_pulse <= 1'b0;
      deadlock_idx   <= '0;
      deadlock_ts    <= '0;
      event_count    <= '0;
    end else begin
      stamp          <= stamp + 1'b1;
      deadlock_pulse <= any_fire;

      if (clear) begin
        state       <= ST_IDLE;
        deadlock    <= 1'b0;
        deadlock_idx <= '0;
        deadlock_ts <= '0;
        event_count <= '0;
      end

      // A clear in the same cycle is applied first, so the event becomes the new first fault.
      if (any_fire) begin
        if (clear || state == ST_IDLE) begin
          state        <= ST_LATCHED;
          deadlock     <= 1'b1;
          deadlock_idx <= first_idx;
          deadlock_ts  <= stamp;
        end
        if (clear) event_count <= EVT_W'(1);
        else if (event_count != EVT_MAX) event_count <= event_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stream_sign_flip_hls_deadlock_reporter.sv
// Directed bench for the deadlock reporter, checked every cycle against a run-length model.
module tb_stream_sign_flip_hls_deadlock_reporter;

  localparam int NUM_MON   = 4;
  localparam int THRESHOLD = 8;
  localparam int TS_W      = 32;
  localparam int EVT_W     = 4;
  localparam int CNT_MAX   = (1 << EVT_W) - 1;

  logic               clock;
  logic               reset;
  logic [NUM_MON-1:0] block_in;
  logic               clear;
  logic               deadlock;
  logic               deadlock_pulse;
  logic [1:0]         deadlock_idx;
  logic [TS_W-1:0]    deadlock_ts;
  logic [EVT_W-1:0]   event_count;

  int checks = 0;
  int errors = 0;

  stream_sign_flip_hls_deadlock_reporter #(
    .NUM_MON   (NUM_MON),
    .THRESHOLD (THRESHOLD),
    .TS_W      (TS_W),
    .EVT_W     (EVT_W)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .block_in       (block_in),
    .clear          (clear),
    .deadlock       (deadlock),
    .deadlock_pulse (deadlock_pulse),
    .deadlock_idx   (deadlock_idx),
    .deadlock_ts    (deadlock_ts),
    .event_count    (event_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: an event is the sample where a monitor's run of consecutive highs reaches THRESHOLD.
  int          run [NUM_MON];
  logic [31:0] m_stamp;
  bit          m_dl, m_pulse, started;
  int          m_idx, m_cnt;
  logic [31:0] m_ts;

  always @(posedge clock) begin
    int first;
    bit ev;
    if (reset) begin
      for (int i = 0; i < NUM_MON; i++) run[i] = 0;
      m_stamp = 0; m_dl = 0; m_pulse = 0; m_idx = 0; m_cnt = 0; m_ts = 0;
      started = 1;
    end else begin
      ev = 0;
      first = -1;
      for (int i = 0; i < NUM_MON; i++) begin
        if (block_in[i]) begin
          run[i]++;
          if (run[i] == THRESHOLD) begin
            ev = 1;
            if (first < 0) first = i;
          end
        end else begin
          run[i] = 0;
        end
      end
      if (clear) begin
        m_dl = 0; m_idx = 0; m_ts = 0; m_cnt = 0;
      end
      if (ev) begin
        if (!m_dl) begin
          m_dl = 1; m_idx = first; m_ts = m_stamp;
        end
        if (m_cnt < CNT_MAX) m_cnt++;
      end
      m_pulse = ev;
      m_stamp = m_stamp + 1;
    end
  end

  always @(negedge clock) begin
    if (started) begin
      chk("deadlock", 64'(deadlock), 64'(m_dl));
      chk("pulse", 64'(deadlock_pulse), 64'(m_pulse));
      chk("idx", 64'(deadlock_idx), 64'(m_idx));
      chk("ts", 64'(deadlock_ts), 64'(m_ts));
      chk("count", 64'(event_count), 64'(m_cnt));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  initial begin
    reset = 1'b1; block_in = '0; clear = 1'b0;
    step(3);
    chk("rst_deadlock", 64'(deadlock), 0);
    chk("rst_count", 64'(event_count), 0);
    reset = 1'b0;

    // Monitor 2 first sampled high at stamp 10, qualifies at stamp 17.
    step(10);
    block_in = 4'b0100;
    step(8);
    block_in = '0;
    chk("s1_pulse", 64'(deadlock_pulse), 1);
    chk("s1_deadlock", 64'(deadlock), 1);
    chk("s1_idx", 64'(deadlock_idx), 2);
    chk("s1_ts", 64'(deadlock_ts), 17);
    chk("s1_count", 64'(event_count), 1);
    step(1);
    chk("s1_pulse_low", 64'(deadlock_pulse), 0);

    // Seven-cycle stalls never qualify; each drop restarts the run.
    do_clear();
    chk("s2_cleared", 64'(deadlock), 0);
    block_in = 4'b0010; step(7);
    block_in = '0;      step(1);
    block_in = 4'b0010; step(7);
    block_in = '0;      step(1);
    chk("s2_deadlock", 64'(deadlock), 0);
    chk("s2_count", 64'(event_count), 0);

    // Simultaneous 3 and 1: lowest index captured; later 0 only bumps the count.
    block_in = 4'b1010; step(8);
    chk("s3_idx", 64'(deadlock_idx), 1);
    chk("s3_count", 64'(event_count), 1);
    block_in = 4'b1011; step(8);
    chk("s3_count2", 64'(event_count), 2);
    chk("s3_idx2", 64'(deadlock_idx), 1);
    block_in = '0; step(1);

    // 40-cycle stall with clear at cycle 20: no re-fire until the stall drops.
    do_clear();
    block_in = 4'b0001; step(19);
    chk("s4_pre_clear", 64'(event_count), 1);
    do_clear();
    step(20);
    chk("s4_deadlock", 64'(deadlock), 0);
    chk("s4_count", 64'(event_count), 0);
    block_in = '0; step(1);
    block_in = 4'b0001; step(8);
    chk("s4_requal", 64'(deadlock), 1);
    chk("s4_requal_cnt", 64'(event_count), 1);
    block_in = '0; step(1);

    // Twenty qualified stalls saturate the 4-bit counter.
    do_clear();
    for (int k = 0; k < 20; k++) begin
      block_in = 4'b0100; step(8);
      block_in = '0;      step(1);
    end
    chk("s5_sat", 64'(event_count), 15);

    // Clear in the same cycle as an event.
    block_in = 4'b0100; step(7);
    clear = 1'b1; step(1);
    clear = 1'b0; block_in = '0;
    chk("s5_co_count", 64'(event_count), 1);
    chk("s5_co_deadlock", 64'(deadlock), 1);
    chk("s5_co_pulse", 64'(deadlock_pulse), 1);
    chk("s5_co_idx", 64'(deadlock_idx), 2);
    step(1);

    // Reset five cycles into a stall; the stall needs a full window afterwards.
    do_clear();
    block_in = 4'b1000; step(5);
    reset = 1'b1; step(2);
    chk("s6_rst_deadlock", 64'(deadlock), 0);
    chk("s6_rst_count", 64'(event_count), 0);
    chk("s6_rst_ts", 64'(deadlock_ts), 0);
    reset = 1'b0;
    step(7);
    chk("s6_early", 64'(deadlock), 0);
    step(1);
    chk("s6_deadlock", 64'(deadlock), 1);
    chk("s6_idx", 64'(deadlock_idx), 3);
    chk("s6_ts", 64'(deadlock_ts), 7);
    block_in = '0; step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
